// File: rtl/irq_pkg.sv
// Shared interrupt-path definitions: request-vector width, code width and
// handshake FSM encoding, common to the latch, the priority encoder and the consumer.
package irq_pkg;

  localparam int IRQ_N      = 8;
  localparam int IRQ_CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } irq_state_e;

  function automatic logic [IRQ_N-1:0] code2mask(
    input logic [IRQ_CODE_W-1:0] code
  );
    logic [IRQ_N-1:0] m;
    m = '0;
    m[code] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Rising-edge detector for the request lines; IRQ_SYNC_EN inserts a
// 2-flop synchronizer (reset high) in front of the detector.
module irq_edge_sync
  import irq_pkg::*;
#(
  parameter int N = IRQ_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] irq_i,
  output logic [N-1:0] rise_o
);

  logic [N-1:0] src;
  logic [N-1:0] prev_q;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= irq_i;
      sync_q <= meta_q;
    end
  end

  assign src = sync_q;
`else
  assign src = irq_i;
`endif

  // Reset to ones so lines already high at release don't fire.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= '1;
    else     prev_q <= src;
  end

  assign rise_o = src & ~prev_q;

endmodule

// File: rtl/irq_request_latch.sv
// Request latch feeding the 8-bit priority encoder, with ack handshake.
// Build option: IRQ_SYNC_EN adds a 2-flop input synchronizer.
module irq_request_latch
  import irq_pkg::*;
#(
  parameter int N      = IRQ_N,
  parameter int CODE_W = IRQ_CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      irq_in,
  input  logic [N-1:0]      mask,
  input  logic              ack,
  input  logic [CODE_W-1:0] ack_code,
  output logic [N-1:0]      req_data,
  output logic [N-1:0]      pending,
  output logic [N-1:0]      overrun,
  output logic              irq_req
);

  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] overrun_q, overrun_d;
  logic         irq_req_q;
  irq_state_e   state_q, state_d;

  irq_edge_sync #(.N(N)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .irq_i  (irq_in),
    .rise_o (rise)
  );

  assign clr = (state_q == ASSERT && ack) ? code2mask(ack_code) : '0;

  // Set beats clear so an edge landing on the ack cycle is kept.
  always_comb begin
    pending_d = rise | (pending_q & ~clr);
    overrun_d = (overrun_q | (rise & pending_q & ~clr)) & ~(clr & ~rise);
  end

  assign req_data = pending_q & mask;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (|req_data) state_d = ASSERT;
      end
      ASSERT: begin
        if (ack)             state_d = HOLD;
        else if (!(|req_data)) state_d = IDLE;
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      overrun_q <= '0;
      state_q   <= IDLE;
      irq_req_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      irq_req_q <= (state_d == ASSERT);
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;
  assign irq_req = irq_req_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch (default build, no synchronizer).
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_irq_request_latch;
  import irq_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] ack_code;
  logic [7:0] req_data;
  logic [7:0] pending;
  logic [7:0] overrun;
  logic       irq_req;

  int n_chk;
  int n_fail;

  irq_request_latch dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .mask     (mask),
    .ack      (ack),
    .ack_code (ack_code),
    .req_data (req_data),
    .pending  (pending),
    .overrun  (overrun),
    .irq_req  (irq_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input logic [2:0] code);
    ack      = 1'b1;
    ack_code = code;
    tick();
    ack      = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    irq_in   = 8'hFF;
    mask     = 8'hFF;
    ack      = 1'b0;
    ack_code = '0;
    tick();
    tick();
    chk("rst_pending", pending, 8'h00);
    chk("rst_overrun", overrun, 8'h00);
    chk("rst_irq_req", irq_req, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hi_at_release_pending", pending, 8'h00);
      chk("hi_at_release_irq_req", irq_req, 1'b0);
    end
    irq_in = 8'h00;
    tick();
    tick();

    // single line, full handshake
    irq_in = 8'h20;
    tick();
    chk("b5_pending", pending, 8'h20);
    chk("b5_req_data", req_data, 8'h20);
    chk("b5_irq_req_k", irq_req, 1'b0);
    tick();
    chk("b5_irq_req_k1", irq_req, 1'b1);
    do_ack(3'd5);
    chk("b5_ack_pending", pending, 8'h00);
    chk("b5_hold_irq_req", irq_req, 1'b0);
    tick();
    chk("b5_idle_irq_req", irq_req, 1'b0);
    tick();
    chk("b5_stay_idle", irq_req, 1'b0);
    irq_in = 8'h00;
    tick();

    // two lines, partial service
    irq_in = 8'h44;
    tick();
    chk("b26_req_data", req_data, 8'h44);
    tick();
    chk("b26_irq_req", irq_req, 1'b1);
    do_ack(3'd6);
    chk("b26_ack_pending", pending, 8'h04);
    chk("b26_hold", irq_req, 1'b0);
    tick();
    chk("b26_idle", irq_req, 1'b0);
    tick();
    chk("b26_reassert", irq_req, 1'b1);
    irq_in = 8'h00;
    do_ack(3'd2);
    chk("b2_cleared", pending, 8'h00);
    tick();

    // set beats clear; overrun on repeat edge
    irq_in = 8'h08;
    tick();
    chk("b3_pending", pending, 8'h08);
    tick();
    chk("b3_irq_req", irq_req, 1'b1);
    irq_in = 8'h00;
    tick();
    irq_in = 8'h08;
    do_ack(3'd3);
    chk("b3_set_wins", pending, 8'h08);
    chk("b3_no_overrun", overrun, 8'h00);
    chk("b3_hold", irq_req, 1'b0);
    tick();
    irq_in = 8'h00;
    tick();
    chk("b3_reassert", irq_req, 1'b1);
    irq_in = 8'h08;
    tick();
    chk("b3_overrun", overrun, 8'h08);
    chk("b3_still_pending", pending, 8'h08);
    irq_in = 8'h00;
    do_ack(3'd3);
    chk("b3_ovr_cleared", overrun, 8'h00);
    chk("b3_pend_cleared", pending, 8'h00);
    tick();

    // masked line, ack outside ASSERT, unmask, mask drop
    mask   = 8'h00;
    irq_in = 8'h02;
    tick();
    chk("m_pending", pending, 8'h02);
    chk("m_req_data", req_data, 8'h00);
    tick();
    chk("m_irq_req", irq_req, 1'b0);
    do_ack(3'd1);
    chk("m_ack_ignored", pending, 8'h02);
    chk("m_ack_no_req", irq_req, 1'b0);
    mask = 8'h02;
    #1;
    chk("m_unmask_comb", req_data, 8'h02);
    tick();
    chk("m_unmask_req", irq_req, 1'b1);
    mask = 8'h00;
    tick();
    chk("m_drop_idle", irq_req, 1'b0);
    chk("m_drop_keep", pending, 8'h02);
    mask = 8'h02;
    tick();
    chk("m_reassert", irq_req, 1'b1);
    irq_in = 8'h00;
    do_ack(3'd1);
    chk("m_cleared", pending, 8'h00);
    tick();
    mask = 8'hFF;

    // reset mid-handshake, with a coincident ack
    irq_in = 8'h81;
    tick();
    chk("r_pending", pending, 8'h81);
    tick();
    chk("r_irq_req", irq_req, 1'b1);
    rst      = 1'b1;
    ack      = 1'b1;
    ack_code = 3'd0;
    tick();
    rst = 1'b0;
    ack = 1'b0;
    chk("r_pending_clr", pending, 8'h00);
    chk("r_irq_req_clr", irq_req, 1'b0);
    tick();
    chk("r_no_rise", pending, 8'h00);
    tick();
    chk("r_idle", irq_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Front-end stage that feeds the 8-bit priority encoder.
- Captures rising edges on eight asynchronous-origin request lines into a pending register and applies an enable mask.
- Presents the masked pending vector as the encoder's Data input.
- Runs a request/acknowledge handshake with the consumer. The consumer returns the encoder's Code as ack_code, which clears the serviced bit.

Parameters:
- N, 8, number of request lines; fixed at 8 to match the encoder width.
- CODE_W, 3, width of ack_code; equals log2(N).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  N  request lines; a rising edge raises a request.
- mask  input  N  1 = line enabled; 0 = line held pending but hidden.
- ack  input  1  consumer acknowledge, single-cycle pulse.
- ack_code  input  CODE_W  index of the serviced line (the encoder Code).
- req_data  output  N  pending & mask; drives encoder Data (combinational from registers).
- pending  output  N  raw pending register.
- overrun  output  N  sticky per-line flag: an edge arrived while the bit was already pending.
- irq_req  output  1  request to the consumer (registered).

Behaviour:
- Reset (rst=1 at a clk edge):
  - pending=0, overrun=0, irq_req=0, state=IDLE.
  - irq_prev=all ones, so lines already high at reset release do not create a request.
- Edge detect: rise[i] = irq_in[i] & ~irq_prev[i], evaluated at each clk edge. irq_prev <= irq_in every cycle.
- Pending update at edge k, per bit i:
  - If rise[i], pending[i] <= 1.
  - Else if clr[i], pending[i] <= 0.
  - clr[i] = (state==ASSERT) & ack & (ack_code==i).
  - Set wins over clear in the same cycle, so a new edge is never lost.
- Overrun update, per bit i:
  - If rise[i] and pending[i] is already 1 and clr[i]=0, overrun[i] <= 1.
  - If clr[i] and no rise[i], overrun[i] <= 0.
- Mask:
  - Affects only req_data and the FSM. Masked lines still latch pending.
  - Unmasking a pending bit makes it visible in req_data in the same cycle, combinationally.
- FSM (encoding in package):
  - IDLE: irq_req=0. If |req_data, go to ASSERT at the next edge.
  - ASSERT: irq_req=1.
    - If ack, go to HOLD.
    - If |req_data drops to 0 because mask changed, go to IDLE with no ack.
  - HOLD: irq_req=0 for exactly one cycle, so the encoder and consumer see the updated vector. Then go to IDLE.
- Latency: edge sampled at clk edge k → pending/req_data valid after edge k → irq_req=1 after edge k+1.
- ack outside ASSERT is ignored: no clear, no state change.
- ack with ack_code pointing at a non-pending bit: no bit clears, but the FSM still goes to HOLD.
- rst mid-handshake: the sequence is abandoned and everything returns to reset values immediately.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined:
  - irq_in passes through a 2-flop synchronizer (reset to all ones) before edge detection.
  - Adds 2 cycles: irq_req=1 after edge k+3 relative to the first sampling edge.
- Undefined:
  - irq_in goes directly to edge detection; the source is assumed synchronous to clk.

Decomposition:
- Shared package irq_pkg:
  - IRQ_N=8 and IRQ_CODE_W=3.
  - FSM state typedef/localparams: IDLE=2'd0, ASSERT=2'd1, HOLD=2'd2.
  - Shared with the priority encoder and consumer.
- One natural sub-module: irq_edge_sync. It holds the optional synchronizer, irq_prev and rise generation, and is instantiated once with N-wide vectors.

Test Plan:
- Reset with irq_in=8'hFF held through release, mask=8'hFF → pending stays 8'h00 and irq_req=0 for 10 cycles.
- Pulse irq_in[5] 0→1 at edge k, mask=8'hFF → pending=8'h20 after k, irq_req=1 after k+1. Then ack=1 with ack_code=5 → pending=8'h00, one HOLD cycle, irq_req stays 0.
- Edges on bits 2 and 6 together → req_data=8'h44. Then ack code 6 → pending=8'h04, irq_req reasserts after HOLD+IDLE.
- Rise on bit 3 in the same cycle as ack code 3 (bit 3 pending) → pending[3] stays 1 and overrun[3] stays 0. A second rise while pending with no ack → overrun[3]=1.
- mask=8'h00 and a pulse on bit 1 → pending=8'h02, req_data=8'h00, irq_req=0. Then set mask=8'h02 → req_data=8'h02 same cycle, irq_req=1 next cycle.
- Assert rst while in ASSERT with pending=8'h81 → next cycle pending=0, irq_req=0, state IDLE. An ack in that cycle has no effect.
